io_input_ctrl: RTL and testbench

//  Memory-mapped input responder in the switch window (0x1001_0000-0x1001_0FFF).
//  - Synchronises and debounces the raw switch and button pins.
//  - Captures button press events in sticky flags and raises an interrupt on enabled flags.
//  - Serves LSU loads combinationally, so a single-cycle core sees read data in the same cycle.
//  - Accepts LSU stores for flag clearing and interrupt enable.

---
 rtl/io_input_ctrl.sv | 129 ++++++++++++
 tb/tb_io_input_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/io_input_ctrl.sv
// io_input_ctrl: memory-mapped switch/button responder.
// Raw pins are synchronised and debounced. Button presses are latched into
// sticky flags that can raise a level interrupt. Loads are answered
// combinationally. Stores clear flags and set the interrupt enable mask.
module io_input_ctrl #(
  parameter int SW_W        = 32,
  parameter int BTN_W       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 500000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sel,
  input  logic [11:0]      i_addr,
  input  logic             i_wren,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  input  logic [SW_W-1:0]  i_io_sw,
  input  logic [BTN_W-1:0] i_io_btn,
  output logic             o_irq
);

  // Switches and buttons share one debounce datapath: {buttons, switches}.
  localparam int NW = SW_W + BTN_W;
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [9:0] {
    REG_SW_STATE  = 10'd0,
    REG_BTN_STATE = 10'd1,
    REG_BTN_EDGE  = 10'd2,
    REG_IRQ_EN    = 10'd3
  } reg_idx_e;

  logic [SW_W-1:0]  r_sw_sync  [SYNC_STAGES];
  logic [BTN_W-1:0] r_btn_sync [SYNC_STAGES];
  logic [NW-1:0]    r_deb;
  logic [CW-1:0]    r_cnt [NW];
  logic [BTN_W-1:0] r_btn_edge;
  logic [BTN_W-1:0] r_irq_en;

  logic [NW-1:0]    w_synced;
  logic [BTN_W-1:0] w_btn_rise;
  logic [BTN_W-1:0] w_edge_clr;
  logic [9:0]       w_word;
  logic             w_wr;

  assign w_word = i_addr[11:2];
  assign w_wr   = i_sel & i_wren;
  // Buttons are active-low on the pin. Invert so that pressed reads as 1.
  assign w_synced = {~r_btn_sync[SYNC_STAGES-1], r_sw_sync[SYNC_STAGES-1]};

  // Synchroniser chains. Buttons reset to the released level (1).
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sw_sync[s]  <= '0;
        r_btn_sync[s] <= '1;
      end
    end else begin
      r_sw_sync[0]  <= i_io_sw;
      r_btn_sync[0] <= i_io_btn;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sw_sync[s]  <= r_sw_sync[s-1];
        r_btn_sync[s] <= r_btn_sync[s-1];
      end
    end
  end

  // Per-bit debounce. The value must hold for DB_CYCLES cycles, and any glitch restarts the count.
  // NOTE: the counter array is reset explicitly, because a reset must discard any pending count.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_deb <= '0;
      for (int i = 0; i < NW; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (w_synced[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_deb[i] <= w_synced[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Debounced button about to go 0->1 on this edge. The flag sets together with BTN_STATE.
  // NOTE: every always_comb output gets a default first so that no latch is inferred.
  always_comb begin
    w_btn_rise = '0;
    for (int i = 0; i < BTN_W; i++) begin
      w_btn_rise[i] = w_synced[SW_W+i] & ~r_deb[SW_W+i] & (r_cnt[SW_W+i] == CNT_MAX);
    end
  end

  assign w_edge_clr = (w_wr && (w_word == REG_BTN_EDGE)) ? i_wdata[BTN_W-1:0] : '0;

  // Sticky press flags (write-1-to-clear; a new press wins over a clear) and the IRQ enable mask.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_btn_edge <= '0;
      r_irq_en   <= '0;
    end else begin
      r_btn_edge <= (r_btn_edge & ~w_edge_clr) | w_btn_rise;
      if (w_wr && (w_word == REG_IRQ_EN)) r_irq_en <= i_wdata[BTN_W-1:0];
    end
  end

  assign o_irq = |(r_btn_edge & r_irq_en);

  // Combinational load mux. Unselected accesses and unmapped offsets read 0.
  always_comb begin
    o_rdata = '0;
    if (i_sel) begin
      case (reg_idx_e'(w_word))
        REG_SW_STATE:  o_rdata[SW_W-1:0]  = r_deb[SW_W-1:0];
        REG_BTN_STATE: o_rdata[BTN_W-1:0] = r_deb[SW_W +: BTN_W];
        REG_BTN_EDGE:  o_rdata[BTN_W-1:0] = r_btn_edge;
        REG_IRQ_EN:    o_rdata[BTN_W-1:0] = r_irq_en;
        default:       o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Bench for io_input_ctrl with DB_CYCLES=4 and SYNC_STAGES=2, so a clean pin edge shows up 6 cycles later.
// Stimulus pushes each expected value into a scoreboard queue. A monitor pops the queue
// and compares on the falling edge of every cycle that has a check pending.
module tb_io_input_ctrl;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_sel;
  logic [11:0] i_addr;
  logic        i_wren;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic [31:0] i_io_sw;
  logic [3:0]  i_io_btn;
  logic        o_irq;

  io_input_ctrl #(
    .SW_W(32), .BTN_W(4), .SYNC_STAGES(2), .DB_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_sel(i_sel), .i_addr(i_addr),
    .i_wren(i_wren), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .i_io_sw(i_io_sw), .i_io_btn(i_io_btn), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  typedef enum {CHK_RDATA, CHK_IRQ} chk_e;
  typedef struct {
    chk_e        kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic mon_valid = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Monitor: compares the DUT against the oldest expectation while a check is pending.
  always @(negedge clk) begin
    if (mon_valid) begin : mon
      exp_t        e;
      logic [31:0] act;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_underflow: check requested with no expectation");
      end else begin
        e   = sb.pop_front();
        act = (e.kind == CHK_IRQ) ? {31'b0, o_irq} : o_rdata;
        if (act !== e.exp) begin
          tests_failed++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
        end
      end
    end
  end

  // Advance one cycle and return the bus to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    mon_valid = 1'b0;
    i_sel     = 1'b0;
    i_wren    = 1'b0;
    i_addr    = '0;
    i_wdata   = '0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string n,
                    input logic sel = 1'b1);
    i_sel  = sel;
    i_addr = a;
    sb.push_back('{CHK_RDATA, e, n});
    mon_valid = 1'b1;
    tick();
  endtask

  task automatic chk_irq(input logic e, input string n);
    sb.push_back('{CHK_IRQ, {31'b0, e}, n});
    mon_valid = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    i_sel   = 1'b1;
    i_wren  = 1'b1;
    i_addr  = a;
    i_wdata = d;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b0; i_sel = 1'b0; i_addr = '0; i_wren = 1'b0; i_wdata = '0;
    i_io_sw = 32'h3FF; i_io_btn = 4'h0;
    tick(); tick();

    // Reset: all registers read 0 and the interrupt is low.
    rd(12'h000, 32'h0, "rst_sw_state");
    rd(12'h004, 32'h0, "rst_btn_state");
    rd(12'h008, 32'h0, "rst_btn_edge");
    rd(12'h00C, 32'h0, "rst_irq_en");
    chk_irq(1'b0, "rst_irq");
    i_rst = 1'b1;
    repeat (5) tick();
    rd(12'h000, 32'h0,   "sw_not_at_5");
    rd(12'h000, 32'h3FF, "sw_at_6");
    rd(12'h004, 32'hF,   "btn_after_rst");
    i_io_btn = 4'hF;
    repeat (8) tick();
    wr(12'h008, 32'hF);
    rd(12'h008, 32'h0, "edge_clear_all");

    // Bounce on sw[0]: toggles at 2-cycle spacing, then held high.
    i_io_sw = 32'h3FE;
    repeat (8) tick();
    rd(12'h000, 32'h3FE, "sw0_low");
    i_io_sw = 32'h3FF;
    rd(12'h000, 32'h3FE, "bounce_1a"); rd(12'h000, 32'h3FE, "bounce_1b");
    i_io_sw = 32'h3FE;
    rd(12'h000, 32'h3FE, "bounce_0a"); rd(12'h000, 32'h3FE, "bounce_0b");
    i_io_sw = 32'h3FF;
    for (int k = 0; k <= 6; k++)
      rd(12'h000, (k == 6) ? 32'h3FF : 32'h3FE, $sformatf("bounce_settle_%0d", k));

    // Press and release btn[2].
    i_io_btn = 4'hB;
    repeat (10) tick();
    rd(12'h004, 32'h4, "btn2_state");
    rd(12'h008, 32'h4, "btn2_edge");
    i_io_btn = 4'hF;
    repeat (8) tick();
    rd(12'h004, 32'h0, "btn2_released");
    rd(12'h008, 32'h4, "edge_sticky");

    // Write-1-to-clear, and a press that lands in the same cycle as a clear wins.
    i_io_btn = 4'hE;
    repeat (8) tick();
    i_io_btn = 4'hF;
    repeat (8) tick();
    rd(12'h008, 32'h5, "edge_5");
    wr(12'h008, 32'h4);
    rd(12'h008, 32'h1, "edge_clr_bit2");
    wr(12'h008, 32'h1);
    rd(12'h008, 32'h0, "edge_clr_bit0");
    i_io_btn = 4'hE;
    repeat (5) tick();
    wr(12'h008, 32'h1);
    rd(12'h008, 32'h1, "set_wins_over_clr");
    i_io_btn = 4'hF;
    repeat (8) tick();
    wr(12'h008, 32'h1);
    rd(12'h008, 32'h0, "edge_clr_after_race");

    // IRQ enable mask and interrupt timing.
    wr(12'h00C, 32'hFFFF_FFFF);
    rd(12'h00C, 32'hF, "irq_en_mask");
    chk_irq(1'b0, "irq_idle");
    i_io_btn = 4'hD;
    repeat (5) tick();
    chk_irq(1'b0, "irq_before_flag");
    chk_irq(1'b1, "irq_after_flag");
    i_io_btn = 4'hF;
    repeat (8) tick();
    rd(12'h008, 32'h2, "edge_2");
    wr(12'h00C, 32'h1);
    chk_irq(1'b0, "irq_masked");
    wr(12'h00C, 32'hF);
    chk_irq(1'b1, "irq_unmasked");
    wr(12'h008, 32'h2);
    chk_irq(1'b0, "irq_cleared");

    // Address map rules.
    rd(12'h010, 32'h0, "unmapped_read");
    rd(12'h000, 32'h0, "sel_low_read", 1'b0);
    rd(12'h00E, 32'hF, "addr_lsbs_ignored");
    wr(12'h000, 32'h1234);
    rd(12'h000, 32'h3FF, "sw_read_only");
    i_sel = 1'b0; i_wren = 1'b1; i_addr = 12'h00C; i_wdata = 32'h0;
    tick();
    rd(12'h00C, 32'hF, "store_without_sel");

    // Reset in the middle of a debounce restarts the full delay.
    i_io_sw = 32'h3FE;
    repeat (4) tick();
    i_rst = 1'b0;
    tick();
    rd(12'h00C, 32'h0, "rst_mid_irq_en");
    i_rst = 1'b1;
    repeat (5) tick();
    rd(12'h000, 32'h0,   "rst_mid_not_at_5");
    rd(12'h000, 32'h3FE, "rst_mid_at_6");

    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
